// File: rtl/memory_port_arbiter.sv
// Round-robin arbiter sharing the unified RAM data port between the CPU (A) and loader/DMA (B).
// Optional ownership locking is compiled in with `define MEM_ARB_LOCK_EN.
module memory_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_a_req,
  input  logic              i_a_we,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [DATA_W-1:0] i_a_wdata,
  output logic              o_a_gnt,
  output logic              o_a_rvalid,
  output logic [DATA_W-1:0] o_a_rdata,
  input  logic              i_b_req,
  input  logic              i_b_we,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [DATA_W-1:0] i_b_wdata,
  output logic              o_b_gnt,
  output logic              o_b_rvalid,
  output logic [DATA_W-1:0] o_b_rdata,
`ifdef MEM_ARB_LOCK_EN
  input  logic              i_a_lock,
  input  logic              i_b_lock,
`endif
  output logic [ADDR_W-1:0] o_mem_address,
  output logic              o_mem_write_enable,
  output logic [DATA_W-1:0] o_mem_data_in,
  input  logic [DATA_W-1:0] i_mem_data_out
);

  logic              r_last_b;
  logic              r_pend_a;
  logic              r_pend_b;
  logic [DATA_W-1:0] r_a_rdata;
  logic [DATA_W-1:0] r_b_rdata;
  logic [ADDR_W-1:0] r_mem_address;

  logic              w_a_elig;
  logic              w_b_elig;
  logic              w_gnt_a;
  logic              w_gnt_b;
  logic              w_any_gnt;
  logic [ADDR_W-1:0] w_mem_address;

`ifdef MEM_ARB_LOCK_EN
  logic r_lock_valid;
  logic r_lock_b;
  logic w_win_lock;
  logic w_owner_req;
`endif

  always_comb begin
    w_a_elig = i_a_req;
    w_b_elig = i_b_req;
`ifdef MEM_ARB_LOCK_EN
    // While locked, the non-owner is masked even if the owner is idle.
    if (r_lock_valid) begin
      w_a_elig = i_a_req & ~r_lock_b;
      w_b_elig = i_b_req & r_lock_b;
    end
`endif
    w_gnt_a   = i_reset_n & w_a_elig & (~w_b_elig | r_last_b);
    w_gnt_b   = i_reset_n & w_b_elig & (~w_a_elig | ~r_last_b);
    w_any_gnt = w_gnt_a | w_gnt_b;

    if (w_gnt_a)      w_mem_address = i_a_addr;
    else if (w_gnt_b) w_mem_address = i_b_addr;
    else              w_mem_address = r_mem_address;
  end

  assign o_a_gnt            = w_gnt_a;
  assign o_b_gnt            = w_gnt_b;
  assign o_mem_address      = w_mem_address;
  assign o_mem_data_in      = w_gnt_b ? i_b_wdata : i_a_wdata;
  assign o_mem_write_enable = (w_gnt_a & i_a_we) | (w_gnt_b & i_b_we);

  // RAM output is only valid in the rvalid cycle; the register keeps it afterwards.
  assign o_a_rvalid = i_reset_n & r_pend_a;
  assign o_b_rvalid = i_reset_n & r_pend_b;
  assign o_a_rdata  = o_a_rvalid ? i_mem_data_out : r_a_rdata;
  assign o_b_rdata  = o_b_rvalid ? i_mem_data_out : r_b_rdata;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_last_b  <= 1'b1;
      r_pend_a  <= 1'b0;
      r_pend_b  <= 1'b0;
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else begin
      if (r_pend_a) r_a_rdata <= i_mem_data_out;
      if (r_pend_b) r_b_rdata <= i_mem_data_out;
      r_pend_a <= w_gnt_a & ~i_a_we;
      r_pend_b <= w_gnt_b & ~i_b_we;
      if (w_any_gnt) r_last_b <= w_gnt_b;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_any_gnt) r_mem_address <= w_mem_address;
  end

`ifdef MEM_ARB_LOCK_EN
  assign w_win_lock  = (w_gnt_a & i_a_lock) | (w_gnt_b & i_b_lock);
  assign w_owner_req = r_lock_b ? i_b_req : i_a_req;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_lock_valid <= 1'b0;
      r_lock_b     <= 1'b0;
    end else if (w_any_gnt) begin
      if (w_win_lock) begin
        r_lock_valid <= 1'b1;
        r_lock_b     <= w_gnt_b;
      end else begin
        r_lock_valid <= 1'b0;
      end
    end else if (r_lock_valid && !w_owner_req) begin
      r_lock_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter: directed tables/sequences plus random traffic vs a port-level model.
// Build with MEM_ARB_LOCK_EN defined to also exercise ownership locking.
module tb_memory_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
`ifdef MEM_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          a_req, a_we, b_req, b_we, a_lock, b_lock;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_din, mem_dout;

  memory_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_a_req(a_req), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
    .o_a_gnt(a_gnt), .o_a_rvalid(a_rvalid), .o_a_rdata(a_rdata),
    .i_b_req(b_req), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
    .o_b_gnt(b_gnt), .o_b_rvalid(b_rvalid), .o_b_rdata(b_rdata),
`ifdef MEM_ARB_LOCK_EN
    .i_a_lock(a_lock), .i_b_lock(b_lock),
`endif
    .o_mem_address(mem_addr), .o_mem_write_enable(mem_we),
    .o_mem_data_in(mem_din), .i_mem_data_out(mem_dout)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 4) return 16'h1A2B;
    return 16'(i * 16'h0101) ^ 16'h5A5A;
  endfunction

  // RAM with a registered read that echoes write data, as the real part does.
  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[7:0]] <= mem_din;
    mem_dout <= mem_we ? mem_din : ram[mem_addr[7:0]];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-port bookkeeping computed from the arbitration rules.
  int            m_last = 1;
  int            m_pend = -1;
  int            m_owner = -1;
  logic [DW-1:0] m_pend_data = '0;
  logic [DW-1:0] m_held [2];
  logic [DW-1:0] ref_mem [256];
  logic [AW-1:0] m_addr = '0;
  bit            m_addr_known = 1'b0;

  task automatic step();
    int w;
    bit rq [2];
    logic [AW-1:0] wa;
    logic [DW-1:0] wd, ea, eb;
    bit wwe, wlk, eva, evb;
    rq[0] = a_req; rq[1] = b_req;
    if (!rst_n)                w = -1;
    else if (m_owner >= 0)     w = rq[m_owner] ? m_owner : -1;
    else if (rq[0] && rq[1])   w = 1 - m_last;
    else if (rq[0])            w = 0;
    else if (rq[1])            w = 1;
    else                       w = -1;
    wa  = (w == 1) ? b_addr  : a_addr;
    wd  = (w == 1) ? b_wdata : a_wdata;
    wwe = (w == 1) ? b_we    : a_we;
    wlk = LOCK_EN && ((w == 1) ? b_lock : a_lock);
    eva = rst_n && m_pend == 0;
    evb = rst_n && m_pend == 1;
    ea  = eva ? m_pend_data : m_held[0];
    eb  = evb ? m_pend_data : m_held[1];
    chk("a_gnt", 32'(a_gnt), 32'(w == 0));
    chk("b_gnt", 32'(b_gnt), 32'(w == 1));
    chk("mem_we", 32'(mem_we), 32'(w >= 0 && wwe));
    if (w >= 0) begin
      chk("mem_addr", 32'(mem_addr), 32'(wa));
      chk("mem_din", 32'(mem_din), 32'(wd));
    end else if (m_addr_known) begin
      chk("mem_addr_hold", 32'(mem_addr), 32'(m_addr));
    end
    chk("a_rvalid", 32'(a_rvalid), 32'(eva));
    chk("b_rvalid", 32'(b_rvalid), 32'(evb));
    chk("a_rdata", 32'(a_rdata), 32'(ea));
    chk("b_rdata", 32'(b_rdata), 32'(eb));
    @(posedge clk);
    if (!rst_n) begin
      m_last = 1; m_pend = -1; m_owner = -1;
      m_held[0] = '0; m_held[1] = '0;
    end else begin
      if (m_pend >= 0) m_held[m_pend] = m_pend_data;
      m_pend = -1;
      if (LOCK_EN) begin
        if (w >= 0 && wlk)                      m_owner = w;
        else if (m_owner >= 0 && w == m_owner)  m_owner = -1;
        else if (m_owner >= 0 && !rq[m_owner])  m_owner = -1;
      end
      if (w >= 0) begin
        m_last = w;
        m_addr = wa;
        m_addr_known = 1'b1;
        if (wwe) ref_mem[wa[7:0]] = wd;
        else begin
          m_pend = w;
          m_pend_data = ref_mem[wa[7:0]];
        end
      end
    end
    #1;
  endtask

  task automatic drive(input bit ar, input bit awe, input logic [AW-1:0] aad, input logic [DW-1:0] awd,
                       input bit br, input bit bwe, input logic [AW-1:0] bad, input logic [DW-1:0] bwd);
    a_req = ar; a_we = awe; a_addr = aad; a_wdata = awd;
    b_req = br; b_we = bwe; b_addr = bad; b_wdata = bwd;
  endtask

  task automatic cyc();
    @(negedge clk);
    step();
  endtask

  typedef struct {
    bit ar, awe; logic [AW-1:0] aad; logic [DW-1:0] awd;
    bit br, bwe; logic [AW-1:0] bad; logic [DW-1:0] bwd;
    bit ea_gnt, eb_gnt, ea_rv, eb_rv;
  } vec_t;
  vec_t vecs [9];

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = init_word(i);
      ref_mem[i] = init_word(i);
    end
    m_held[0] = '0; m_held[1] = '0;
    a_lock = 1'b0; b_lock = 1'b0;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Test 1: lone A read of word 4
    drive(1, 0, 16'h0004, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t1_a_gnt", 32'(a_gnt), 32'd1);
    chk("t1_b_gnt", 32'(b_gnt), 32'd0);
    step();
    drive(0, 0, 16'h0004, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t1_a_rvalid", 32'(a_rvalid), 32'd1);
    chk("t1_a_rdata", 32'(a_rdata), 32'h1A2B);
    chk("t1_b_rvalid", 32'(b_rvalid), 32'd0);
    step();

    // Table: contention from reset, then single requesters
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    vecs[0] = '{1'b1, 1'b0, 16'h20, 16'h0, 1'b1, 1'b0, 16'h40, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 16'h21, 16'h0, 1'b1, 1'b0, 16'h41, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 16'h22, 16'h0, 1'b1, 1'b0, 16'h42, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 16'h23, 16'h0, 1'b1, 1'b0, 16'h43, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 16'h24, 16'h0, 1'b1, 1'b0, 16'h44, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 16'h30, 16'hBEEF, 1'b0, 1'b0, 16'h45, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 16'h26, 16'h0, 1'b0, 1'b0, 16'h46, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 16'h27, 16'h0, 1'b1, 1'b0, 16'h47, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 16'h28, 16'h0, 1'b0, 1'b0, 16'h48, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].ar, vecs[i].awe, vecs[i].aad, vecs[i].awd,
            vecs[i].br, vecs[i].bwe, vecs[i].bad, vecs[i].bwd);
      @(negedge clk);
      chk($sformatf("tbl%0d_a_gnt", i), 32'(a_gnt), 32'(vecs[i].ea_gnt));
      chk($sformatf("tbl%0d_b_gnt", i), 32'(b_gnt), 32'(vecs[i].eb_gnt));
      chk($sformatf("tbl%0d_a_rv", i), 32'(a_rvalid), 32'(vecs[i].ea_rv));
      chk($sformatf("tbl%0d_b_rv", i), 32'(b_rvalid), 32'(vecs[i].eb_rv));
      step();
    end

    // Test 3: B write then A read of the same word
    drive(0, 0, 0, 0, 1, 1, 16'h0010, 16'h00FF);
    @(negedge clk);
    chk("t3_b_gnt", 32'(b_gnt), 32'd1);
    step();
    drive(1, 0, 16'h0010, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t3_a_gnt", 32'(a_gnt), 32'd1);
    chk("t3_b_rvalid", 32'(b_rvalid), 32'd0);
    step();
    drive(0, 0, 16'h0010, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t3_a_rvalid", 32'(a_rvalid), 32'd1);
    chk("t3_a_rdata", 32'(a_rdata), 32'h00FF);
    chk("t3_b_rvalid2", 32'(b_rvalid), 32'd0);
    step();

    // Test 4: reset right after a read grant
    drive(1, 0, 16'h0004, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t4_a_gnt", 32'(a_gnt), 32'd1);
    step();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t4_rst_a_rvalid", 32'(a_rvalid), 32'd0);
    chk("t4_rst_mem_we", 32'(mem_we), 32'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t4_post_a_rvalid", 32'(a_rvalid), 32'd0);
    chk("t4_post_a_rdata", 32'(a_rdata), 32'd0);
    step();
    drive(1, 0, 16'h0050, 0, 1, 0, 16'h0051, 0);
    @(negedge clk);
    chk("t4_first_a_gnt", 32'(a_gnt), 32'd1);
    chk("t4_first_b_gnt", 32'(b_gnt), 32'd0);
    step();

`ifdef MEM_ARB_LOCK_EN
    // Test 5: B locked burst of three writes while A waits
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 16'h0050, 0, 1, 1, 16'(16'h0060 + i), 16'(i + 1));
      b_lock = (i < 2);
      @(negedge clk);
      chk($sformatf("t5_b_gnt%0d", i), 32'(b_gnt), 32'd1);
      chk($sformatf("t5_a_gnt%0d", i), 32'(a_gnt), 32'd0);
      step();
    end
    b_lock = 1'b0;
    drive(1, 0, 16'h0050, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t5_a_gnt3", 32'(a_gnt), 32'd1);
    step();
`endif

    // Test 6: A withdraws its request before being granted
    drive(1, 0, 16'h0070, 0, 1, 1, 16'h0071, 16'h1234);
    b_lock = LOCK_EN;
    @(negedge clk);
    chk("t6_b_gnt", 32'(b_gnt), 32'd1);
    chk("t6_a_gnt", 32'(a_gnt), 32'd0);
    step();
    b_lock = 1'b0;
    drive(0, 0, 16'h0070, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t6_a_gnt_drop", 32'(a_gnt), 32'd0);
    step();
    @(negedge clk);
    chk("t6_a_rvalid", 32'(a_rvalid), 32'd0);
    step();

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom_range(0, 255)), 16'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom_range(0, 255)), 16'($urandom));
      a_lock = ($urandom_range(0, 3) == 0);
      b_lock = ($urandom_range(0, 3) == 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
